muldiv_seq: RTL and testbench

Parametrised sequential multiply/divide unit that succeeds the fixed 32-bit mult_div block in the multicycle datapath. It takes operands from registers A and B and runs a radix-2 iterative signed or unsigned MULT/DIV. It then presents HI/LO results with a start/busy/done handshake, so the control unit waits on `done` instead of counting cycles. Its `done` output drives the load enables of the external Hi and Lo registers.

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/muldiv_sign_fix.sv | 11 +
 rtl/muldiv_seq.sv | 118 +++++++++++
 tb/tb_muldiv_seq.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and counter-width helper for muldiv_seq.
package muldiv_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate, used for operand
// magnitudes and result sign correction.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);
    assign y_o = neg_i ? -x_i : x_i;
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: radix-2 iterative multiply/divide with start/busy/done handshake.
// Signed MULT/DIV with sign correction only when MULDIV_SIGNED_EN is defined.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q;
    logic               busy_q, done_q, dz_q, is_div_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   mcand_q, hi_q, lo_q, hi_d, lo_d, a_mag, b_mag, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod_fix;
    logic [WIDTH:0]     sum, diff;
    logic               is_div;

    assign is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);

`ifdef MULDIV_SIGNED_EN
    logic sgn, a_neg, b_neg, neg_q, rneg_q;
    assign sgn   = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign a_neg = sgn & a_i[WIDTH-1];
    assign b_neg = sgn & b_i[WIDTH-1];
    muldiv_sign_fix #(.W(WIDTH))   u_a (.neg_i(a_neg),  .x_i(a_i),                   .y_o(a_mag));
    muldiv_sign_fix #(.W(WIDTH))   u_b (.neg_i(b_neg),  .x_i(b_i),                   .y_o(b_mag));
    muldiv_sign_fix #(.W(2*WIDTH)) u_p (.neg_i(neg_q),  .x_i(acc_q),                 .y_o(prod_fix));
    muldiv_sign_fix #(.W(WIDTH))   u_q (.neg_i(neg_q),  .x_i(acc_q[WIDTH-1:0]),      .y_o(quo_fix));
    muldiv_sign_fix #(.W(WIDTH))   u_r (.neg_i(rneg_q), .x_i(acc_q[2*WIDTH-1:WIDTH]), .y_o(rem_fix));
`else
    assign a_mag    = a_i;
    assign b_mag    = b_i;
    assign prod_fix = acc_q;
    assign quo_fix  = acc_q[WIDTH-1:0];
    assign rem_fix  = acc_q[2*WIDTH-1:WIDTH];
`endif

    // mult: acc = {partial, multiplier}; div: acc = {remainder, dividend/quotient}
    assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign diff  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
    assign acc_d = is_div_q
                 ? {(diff[WIDTH] ? acc_q[2*WIDTH-2:WIDTH-1] : diff[WIDTH-1:0]), acc_q[WIDTH-2:0], ~diff[WIDTH]}
                 : {sum, acc_q[WIDTH-1:1]};
    assign hi_d  = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_d  = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i && is_div && b_i == '0) begin
                        done_q <= 1'b1;
                        dz_q   <= 1'b1;
                    end else if (start_i) begin
                        is_div_q <= is_div;
                        mcand_q  <= is_div ? b_mag : a_mag;
                        acc_q    <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                        cnt_q    <= CNT_W'(WIDTH);
                        busy_q   <= 1'b1;
                        state_q  <= ST_CALC;
`ifdef MULDIV_SIGNED_EN
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
`endif
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors for muldiv_seq (WIDTH=32), expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
    } vec_t;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;
    int          checks = 0, failures = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo), .div_zero_o(dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // counts edges from the launch edge until done, bounded
    task automatic wait_done(input int lat0, output int lat, output int bc);
        lat = lat0;
        bc  = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (busy) bc++;
        end
        check("done_seen", {63'b0, done}, 64'd1);
    endtask

    vec_t v[11];
    int   lat, bc, dcount;

    initial begin
        v[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        v[4] = '{OP_MULTU, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0};
        v[5] = '{OP_DIVU, 32'd100, 32'd0, 32'd0, 32'd25, 1'b1};
        v[6] = '{OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0};
        v[9] = '{OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0};
        v[10] = '{OP_DIV, 32'hFFFFFFF9, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b1};
`ifdef MULDIV_SIGNED_EN
        v[1] = '{OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        v[2] = '{OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        v[3] = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0};
        v[7] = '{OP_MULT, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'd0, 1'b0};
        v[8] = '{OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0};
`else
        v[1] = '{OP_MULT, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 1'b0};
        v[2] = '{OP_DIV, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 1'b0};
        v[3] = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
        v[7] = '{OP_MULT, 32'h80000000, 32'd2, 32'd1, 32'd0, 1'b0};
        v[8] = '{OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd0, 1'b0};
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_dz", {63'b0, dz}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        @(negedge clk) reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            launch(v[i].op, v[i].a, v[i].b);
            wait_done(0, lat, bc);
            check($sformatf("v%0d_hi", i), {32'b0, hi}, {32'b0, v[i].hi});
            check($sformatf("v%0d_lo", i), {32'b0, lo}, {32'b0, v[i].lo});
            check($sformatf("v%0d_dz", i), {63'b0, dz}, {63'b0, v[i].dz});
            check($sformatf("v%0d_lat", i), 64'(lat), v[i].dz ? 64'd0 : 64'd33);
            check($sformatf("v%0d_busy", i), 64'(bc), v[i].dz ? 64'd0 : 64'd33);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pulse", i), {62'b0, done, dz}, 64'd0);
        end

        // start during busy is ignored; start in the done cycle is accepted
        launch(OP_DIVU, 32'd1000, 32'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        op = OP_MULTU; a = 32'd3; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(5, lat, bc);
        check("ign_lat", 64'(lat), 64'd33);
        check("ign_hi", {32'b0, hi}, 64'd6);
        check("ign_lo", {32'b0, lo}, 64'd142);
        op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy", {63'b0, busy}, 64'd1);
        wait_done(0, lat, bc);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_lo", {32'b0, lo}, 64'd12);

        // reset mid-operation abandons it without a done pulse
        launch(OP_MULTU, 32'd7, 32'd9);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", {63'b0, busy}, 64'd0);
        check("mid_rst_done", {63'b0, done}, 64'd0);
        check("mid_rst_hi", {32'b0, hi}, 64'd0);
        check("mid_rst_lo", {32'b0, lo}, 64'd0);
        @(negedge clk) reset_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("no_done_after_rst", 64'(dcount), 64'd0);
        launch(OP_MULTU, 32'd3, 32'd4);
        wait_done(0, lat, bc);
        check("post_rst_hi", {32'b0, hi}, 64'd0);
        check("post_rst_lo", {32'b0, lo}, 64'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
